fma16_issue: RTL and testbench

- Issue/sequencing stage directly upstream of the combinational fp16 multiply-accumulate unit.
- Accepts opcode-tagged operand triples over a valid/ready handshake and buffers them in a small command FIFO.
- Decodes each opcode into the unit's mul/add/negr/negz controls and holds operands stable for a fixed multicycle settle window.
- Captures the 16-bit result and returns it with its tag over a second valid/ready handshake.

---
 rtl/fma16_issue_if.sv | 41 ++++
 rtl/fma16_issue.sv | 200 ++++++++++++++++++++
 tb/tb_fma16_issue.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fma16_issue_if.sv
// fma16_issue_if
//   Command and result channels of the fp16 FMA issue stage.
//   Both channels use the same handshake. A transfer happens on a rising
//   clk edge where valid and ready are both high. A producer holds valid
//   and its payload steady until that transfer. Ready may change freely.
//   Ports (signals):
//     in_valid/in_ready     command handshake
//     in_op/in_x/in_y/in_z  opcode and fp16 operands
//     in_rm/in_tag          rounding mode and opaque ID
//     out_valid/out_ready   result handshake
//     out_result/out_tag    captured fp16 result and its ID
//   Modports: master = upstream producer / downstream consumer side,
//             slave  = the issue stage itself.
interface fma16_issue_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [15:0] in_x;
   logic [15:0] in_y;
   logic [15:0] in_z;
   logic [1:0]  in_rm;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic [3:0]  out_tag;

   modport master (
      output in_valid, in_op, in_x, in_y, in_z, in_rm, in_tag,
      input  in_ready,
      input  out_valid, out_result, out_tag,
      output out_ready
   );

   modport slave (
      input  in_valid, in_op, in_x, in_y, in_z, in_rm, in_tag,
      output in_ready,
      output out_valid, out_result, out_tag,
      input  out_ready
   );
endinterface

// File: rtl/fma16_issue.sv
// fma16_issue
//   Issue/sequencing stage in front of a combinational fp16 multiply-add
//   unit. Commands are buffered in a DEPTH-entry FIFO. Each popped command
//   is decoded into mul/add/negr/negz controls and its operands are held on
//   the fma_* outputs for SETTLE cycles. fma_result is then captured and
//   returned with the command tag.
//   Ports:
//     clk, reset        rising-edge clock, async active-high reset
//     bus (slave)       command channel in, result channel out
//     fma_x/y/z, fma_rm operands and rounding mode to the FMA unit
//     fma_mul/add/negr/negz  decoded controls to the FMA unit
//     fma_result        combinational result from the FMA unit
//     err_op            one-cycle pulse after an illegal opcode is dropped
//     busy              FIFO non-empty or sequencer not idle
//     dbg_state         current sequencer state (IDLE=0, EXEC=1, HOLD=2)
module fma16_issue #(
   parameter int DEPTH  = 4,
   parameter int SETTLE = 2
) (
   input  logic          clk,
   input  logic          reset,
   fma16_issue_if.slave  bus,
   output logic [15:0]   fma_x,
   output logic [15:0]   fma_y,
   output logic [15:0]   fma_z,
   output logic          fma_mul,
   output logic          fma_add,
   output logic          fma_negr,
   output logic          fma_negz,
   output logic [1:0]    fma_rm,
   input  logic [15:0]   fma_result,
   output logic          err_op,
   output logic          busy,
   output logic [1:0]    dbg_state
);

   localparam int AW = $clog2(DEPTH);
   // cnt only has to hold SETTLE-1
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } state_t;

   typedef struct packed {
      logic [2:0]  op;
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] z;
      logic [1:0]  rm;
      logic [3:0]  tag;
   } cmd_t;

   // Returns {mul, add, negr, negz}
   function automatic logic [3:0] decode(input logic [2:0] op);
      logic [3:0] c;
      c = 4'b0000;
      case (op)
         3'b000:  c = 4'b0100;  // fadd
         3'b001:  c = 4'b0101;  // fsub
         3'b010:  c = 4'b1000;  // fmul
         3'b011:  c = 4'b1100;  // fmadd
         3'b100:  c = 4'b1101;  // fmsub
         3'b101:  c = 4'b1110;  // fnmadd
         3'b110:  c = 4'b1111;  // fnmsub
         default: c = 4'b0000;  // never enqueued
      endcase
      return c;
   endfunction

   cmd_t          mem [DEPTH];
   cmd_t          cmd_in;
   cmd_t          head;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          full;
   logic          empty;
   logic          illegal;
   logic          push;
   logic          pop;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [3:0]    cur_tag;
   logic          out_valid_q;
   logic [15:0]   out_result_q;
   logic [3:0]    out_tag_q;

   assign cmd_in  = {bus.in_op, bus.in_x, bus.in_y, bus.in_z, bus.in_rm, bus.in_tag};
   assign head    = mem[rd_ptr];
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign illegal = (bus.in_op == 3'b111);

   // in_ready depends only on registered occupancy, so a pop on the same
   // edge never frees a slot for a push that is waiting on a full FIFO.
   assign bus.in_ready = !full;
   assign push = bus.in_valid && !full && !illegal;

   // Pop uses the occupancy before the edge, so a command pushed on the
   // edge where the FIFO empties is popped one edge later. HOLD always has
   // out_valid high, so out_ready alone completes the result handshake.
   assign pop = !empty && ((state == IDLE) || ((state == HOLD) && bus.out_ready));

   assign bus.out_valid  = out_valid_q;
   assign bus.out_result = out_result_q;
   assign bus.out_tag    = out_tag_q;
   assign busy           = !empty || (state != IDLE);
   assign dbg_state      = state;

   // The storage array has no reset. Entries are written before they can be read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= cmd_in;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         cur_tag      <= '0;
         fma_x        <= '0;
         fma_y        <= '0;
         fma_z        <= '0;
         fma_rm       <= '0;
         fma_mul      <= 1'b0;
         fma_add      <= 1'b0;
         fma_negr     <= 1'b0;
         fma_negz     <= 1'b0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_tag_q    <= '0;
         err_op       <= 1'b0;
      end else begin
         err_op <= bus.in_valid && !full && illegal;

         // The fma_* registers change only on a pop. They keep the last
         // command while idle.
         if (pop) begin
            fma_x   <= head.x;
            fma_y   <= head.y;
            fma_z   <= head.z;
            fma_rm  <= head.rm;
            {fma_mul, fma_add, fma_negr, fma_negz} <= decode(head.op);
            cur_tag <= head.tag;
            cnt     <= CW'(SETTLE - 1);
         end

         case (state)
            IDLE: begin
               if (pop) begin
                  state <= EXEC;
               end
            end
            EXEC: begin
               if (cnt == '0) begin
                  out_result_q <= fma_result;
                  out_tag_q    <= cur_tag;
                  out_valid_q  <= 1'b1;
                  state        <= HOLD;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state       <= pop ? EXEC : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fma16_issue.sv
// tb_fma16_issue
//   Bench for fma16_issue with DEPTH=4 and SETTLE=2. The FMA unit stand-in
//   returns fma_x ^ fma_z. Expected results live in a queue of
//   {controls, x, tag, x^z} records in command order.
module tb_fma16_issue;
   localparam int DEPTH  = 4;
   localparam int SETTLE = 2;
   localparam int W      = 40;

   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] fma_x, fma_y, fma_z, fma_result;
   logic        fma_mul, fma_add, fma_negr, fma_negz;
   logic [1:0]  fma_rm;
   logic        err_op, busy;
   logic [1:0]  dbg_state;

   fma16_issue_if bus ();

   fma16_issue #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .fma_x      (fma_x),
      .fma_y      (fma_y),
      .fma_z      (fma_z),
      .fma_mul    (fma_mul),
      .fma_add    (fma_add),
      .fma_negr   (fma_negr),
      .fma_negz   (fma_negz),
      .fma_rm     (fma_rm),
      .fma_result (fma_result),
      .err_op     (err_op),
      .busy       (busy),
      .dbg_state  (dbg_state)
   );

   assign fma_result = fma_x ^ fma_z;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int vectors     = 0;
   int miscompares = 0;
   logic [W-1:0] exp_q[$];

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Controls from the opcode meaning. fadd/fsub only add, fmul only
   // multiplies, the fused forms do both. The "n" forms negate the product
   // and the "sub" forms negate the addend.
   function automatic logic [3:0] ref_ctrl(input logic [2:0] op);
      logic mul, add, negr, negz;
      mul  = (op >= 3'd2) && (op <= 3'd6);
      add  = (op != 3'd2) && (op != 3'd7);
      negr = (op == 3'd5) || (op == 3'd6);
      negz = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
      return {mul, add, negr, negz};
   endfunction

   function automatic logic [W-1:0] make_exp(input logic [2:0] op, input logic [15:0] x,
                                             input logic [15:0] z, input logic [3:0] tag);
      return {ref_ctrl(op), x, tag, x ^ z};
   endfunction

   function automatic logic [W-1:0] obs_vec();
      return {fma_mul, fma_add, fma_negr, fma_negz, fma_x, bus.out_tag, bus.out_result};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_cmd(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                            input logic [15:0] z, input logic [1:0] rm, input logic [3:0] tag);
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_x     = x;
      bus.in_y     = y;
      bus.in_z     = z;
      bus.in_rm    = rm;
      bus.in_tag   = tag;
   endtask

   task automatic send(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] z, input logic [1:0] rm, input logic [3:0] tag);
      logic done;
      done = 1'b0;
      drive_cmd(op, x, y, z, rm, tag);
      for (int i = 0; i < 50 && !done; i++) begin
         done = bus.in_ready;
         tick();
      end
      bus.in_valid = 1'b0;
      check("send_accept", done, 1);
      if (done && op != 3'd7) exp_q.push_back(make_exp(op, x, z, tag));
   endtask

   task automatic wait_out();
      int n;
      n = 0;
      while (!bus.out_valid && n < 40) begin
         tick();
         n++;
      end
      check("out_valid_wait", bus.out_valid, 1);
   endtask

   task automatic check_head(input string tag);
      check("sb_nonempty", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check(tag, obs_vec(), exp_q[0]);
   endtask

   task automatic consume();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
   endtask

   // Drains with out_ready held high. Optionally checks the result cadence.
   task automatic drain(input string tag, input logic check_gap);
      int last;
      last = -1;
      bus.out_ready = 1'b1;
      for (int cyc = 0; cyc < 200 && exp_q.size() != 0; cyc++) begin
         if (bus.out_valid) begin
            check_head(tag);
            if (check_gap && last >= 0) check("drain_gap", cyc - last, SETTLE + 1);
            last = cyc;
            void'(exp_q.pop_front());
         end
         tick();
      end
      bus.out_ready = 1'b0;
      check("drain_done", exp_q.size(), 0);
      check("drain_idle_busy", busy, 0);
      check("drain_idle_valid", bus.out_valid, 0);
   endtask

   // ---------------- directed + random sequence ----------------
   logic [15:0] x, y, z;
   logic [1:0]  rm;
   logic [3:0]  tg;
   logic [2:0]  op;
   logic        in_fire, out_fire, exp_err;

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_op     = '0;
      bus.in_x      = '0;
      bus.in_y      = '0;
      bus.in_z      = '0;
      bus.in_rm     = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b0;

      // reset state
      #2 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_err_op", err_op, 0);
      check("rst_fma", {fma_mul, fma_add, fma_negr, fma_negz, fma_x, fma_y, fma_z, fma_rm}, 0);
      check("rst_out", {bus.out_tag, bus.out_result}, 0);
      reset = 1'b0;
      tick();

      // single fmul, cycle-exact latency
      drive_cmd(3'd2, 16'h3C00, 16'h4000, 16'h1234, 2'd1, 4'd5);
      check("t1_in_ready", bus.in_ready, 1);
      tick();                                   // edge 0: accept
      bus.in_valid = 1'b0;
      exp_q.push_back(make_exp(3'd2, 16'h3C00, 16'h1234, 4'd5));
      check("t1_busy", busy, 1);
      check("t1_e0_valid", bus.out_valid, 0);
      tick();                                   // edge 1: pop
      check("t1_ctrl", {fma_mul, fma_add, fma_negr, fma_negz}, 4'b1000);
      check("t1_ops", {fma_x, fma_y, fma_z, fma_rm}, {16'h3C00, 16'h4000, 16'h1234, 2'd1});
      tick();                                   // edge 2
      check("t1_e2_valid", bus.out_valid, 0);
      tick();                                   // edge 3: capture
      check("t1_e3_valid", bus.out_valid, 1);
      check("t1_result", bus.out_result, 16'h2E34);
      check("t1_tag", bus.out_tag, 4'd5);
      check_head("t1_sb");
      consume();
      check("t1_valid_clr", bus.out_valid, 0);
      check("t1_busy_clr", busy, 0);

      // opcode sweep with random operands
      for (int k = 0; k < 7; k++) begin
         x = 16'($urandom); y = 16'($urandom); z = 16'($urandom);
         rm = 2'($urandom_range(0, 3)); tg = 4'($urandom_range(0, 15));
         send(3'(k), x, y, z, rm, tg);
         wait_out();
         check("sweep_yzrm", {fma_y, fma_z, fma_rm}, {y, z, rm});
         check_head("sweep_head");
         consume();
      end

      // illegal opcode: accepted, dropped, err_op pulses once
      drive_cmd(3'd7, 16'hAAAA, 16'h5555, 16'h0F0F, 2'd2, 4'd9);
      check("ill_ready", bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
      check("ill_err", err_op, 1);
      check("ill_busy", busy, 0);
      check("ill_ctrl_kept", {fma_mul, fma_add, fma_negr, fma_negz}, ref_ctrl(3'd6));
      tick();
      check("ill_err_once", err_op, 0);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("ill_no_valid", bus.out_valid, 0);
         check("ill_no_busy", busy, 0);
      end

      // backpressure: 5 commands, in_ready drops, HOLD stays stable
      for (int i = 0; i < 5; i++) begin
         x = 16'($urandom) | 16'h0001; y = 16'($urandom); z = 16'($urandom);
         send(3'($urandom_range(0, 6)), x, y, z, 2'($urandom_range(0, 3)), 4'(8 + i));
      end
      check("fill_in_ready", bus.in_ready, 0);
      check("fill_hold_valid", bus.out_valid, 1);
      for (int i = 0; i < 10; i++) begin
         check_head("hold_stable");
         tick();
      end

      // full FIFO with in_valid held through the pop edge
      drive_cmd(3'd3, 16'h1357, 16'h2468, 16'h7531, 2'd0, 4'hD);
      bus.out_ready = 1'b1;
      check("full_no_ready", bus.in_ready, 0);
      check_head("hold_release");
      tick();                                   // pop edge: no push
      void'(exp_q.pop_front());
      check("pop_edge_no_push", bus.in_ready, 1);
      tick();                                   // push lands here
      bus.in_valid = 1'b0;
      exp_q.push_back(make_exp(3'd3, 16'h1357, 16'h7531, 4'hD));
      check("next_edge_push", bus.in_ready, 0);
      drain("drain_order", 1'b1);

      // reset while executing with two commands queued
      for (int i = 0; i < 3; i++) begin
         send(3'($urandom_range(0, 6)), 16'($urandom) | 16'h0001, 16'($urandom),
              16'($urandom), 2'd1, 4'(i));
      end
      check("mid_busy", busy, 1);
      check("mid_no_valid", bus.out_valid, 0);
      #2 reset = 1'b1;
      #1;
      check("arst_out_valid", bus.out_valid, 0);
      check("arst_in_ready", bus.in_ready, 1);
      check("arst_busy", busy, 0);
      check("arst_fma_x", fma_x, 0);
      #2 reset = 1'b0;
      exp_q.delete();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick();
         check("post_rst_no_valid", bus.out_valid, 0);
         check("post_rst_no_busy", busy, 0);
      end
      bus.out_ready = 1'b0;

      // random traffic on both channels
      exp_err = 1'b0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         check("rnd_err_op", err_op, exp_err);
         if (!bus.in_valid && $urandom_range(0, 2) != 0) begin
            op = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            drive_cmd(op, 16'($urandom), 16'($urandom), 16'($urandom),
                      2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
         in_fire  = bus.in_valid && bus.in_ready;
         out_fire = bus.out_valid && bus.out_ready;
         if (out_fire) begin
            check_head("rnd_out");
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end
         exp_err = in_fire && (bus.in_op == 3'd7);
         if (in_fire && bus.in_op != 3'd7)
            exp_q.push_back(make_exp(bus.in_op, bus.in_x, bus.in_z, bus.in_tag));
         tick();
         if (in_fire) bus.in_valid = 1'b0;
      end
      bus.in_valid = 1'b0;
      check("rnd_err_last", err_op, exp_err);
      drain("rnd_drain", 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
